// File: rtl/instr_register_pkg.sv
// Shared CPU definitions: bus/field widths, opcode encodings and the
// instruction-register FSM state encoding.
package instr_register_pkg;

  // Default widths: one instruction is two data-bus beats.
  localparam int DATA_W_DEF = 8;
  localparam int OPC_W_DEF  = 3;
  localparam int ADDR_W_DEF = 13;

  // Opcode encodings as seen by the controller (no decoding in the IR).
  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  // Instruction-register fetch FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } ir_state_e;

endpackage : instr_register_pkg

// File: rtl/instr_register.sv
// Instruction register: assembles a 16-bit instruction from two bus beats
// (high byte first) while load_ir is high, splits it into opcode and
// operand address, and reports fetch progress and aborted fetches.
module instr_register
  import instr_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_ir,
  input  logic              halt,
  input  logic [DATA_W-1:0] data,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  // A beat is only accepted when the controller is not halted.
  logic step_s;
  assign step_s = load_ir & ~halt;

  ir_state_e         state_r;
  ir_state_e         state_s;
  logic [DATA_W-1:0] hi_hold_r;
  logic [DATA_W-1:0] hi_hold_s;
  logic [OPC_W-1:0]  opcode_r;
  logic [OPC_W-1:0]  opcode_s;
  logic [ADDR_W-1:0] ir_addr_r;
  logic [ADDR_W-1:0] ir_addr_s;
  logic              ir_valid_r;
  logic              ir_valid_s;
  logic              fetch_busy_r;
  logic              fetch_busy_s;
  logic              fetch_err_r;
  logic              fetch_err_s;

  // State, holding and output registers; a reset mid-fetch drops the held byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      hi_hold_r    <= {DATA_W{1'b0}};
      opcode_r     <= {OPC_W{1'b0}};
      ir_addr_r    <= {ADDR_W{1'b0}};
      ir_valid_r   <= 1'b0;
      fetch_busy_r <= 1'b0;
      fetch_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      hi_hold_r    <= hi_hold_s;
      opcode_r     <= opcode_s;
      ir_addr_r    <= ir_addr_s;
      ir_valid_r   <= ir_valid_s;
      fetch_busy_r <= fetch_busy_s;
      fetch_err_r  <= fetch_err_s;
    end
  end

  // Next-state logic: halt freezes the FSM; otherwise every cycle in HI leaves HI.
  always_comb begin
    state_s = state_r;
    if (halt) begin
      state_s = state_r;
    end else begin
      case (state_r)
        IDLE:    state_s = load_ir ? HI : IDLE;
        HI:      state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Next values of the data/status registers for each FSM transition.
  always_comb begin
    hi_hold_s    = hi_hold_r;
    opcode_s     = opcode_r;
    ir_addr_s    = ir_addr_r;
    ir_valid_s   = ir_valid_r;
    fetch_busy_s = fetch_busy_r;
    // The error flag is a single-cycle pulse, cleared on every edge.
    fetch_err_s  = 1'b0;
    if (halt) begin
      fetch_err_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (step_s) begin
            // Starting a new fetch supersedes the previous instruction.
            hi_hold_s    = data;
            ir_valid_s   = 1'b0;
            fetch_busy_s = 1'b1;
          end else begin
            fetch_busy_s = fetch_busy_r;
          end
        end
        HI: begin
          if (step_s) begin
            // Both fields change on the same edge so the controller never
            // sees a mixed old/new instruction.
            {opcode_s, ir_addr_s} = {hi_hold_r, data};
            ir_valid_s   = 1'b1;
            fetch_busy_s = 1'b0;
          end else begin
            // Controller dropped load_ir between beats: abort, keep old fields.
            fetch_busy_s = 1'b0;
            fetch_err_s  = 1'b1;
          end
        end
        default: begin
          fetch_busy_s = 1'b0;
          ir_valid_s   = 1'b0;
        end
      endcase
    end
  end

  assign opcode     = opcode_r;
  assign ir_addr    = ir_addr_r;
  assign ir_valid   = ir_valid_r;
  assign fetch_busy = fetch_busy_r;
  assign fetch_err  = fetch_err_r;

endmodule : instr_register

// File: tb/tb_instr_register.sv
// Testbench for instr_register: directed scenarios plus random traffic,
// checked through an expected-response queue against a byte-queue model.
module tb_instr_register;

  logic        clk;
  logic        rst;
  logic        load_ir;
  logic        halt;
  logic [7:0]  data;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_err;

  instr_register dut (
    .clk        (clk),
    .rst        (rst),
    .load_ir    (load_ir),
    .halt       (halt),
    .data       (data),
    .opcode     (opcode),
    .ir_addr    (ir_addr),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  opc;
    logic [12:0] addr;
    logic        valid;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: bytes of the instruction being fetched, plus last result.
  logic [7:0]  bytes_q[$];
  logic [2:0]  m_opc   = 3'd0;
  logic [12:0] m_addr  = 13'd0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;

  function automatic exp_t model_now();
    exp_t e;
    e.opc   = m_opc;
    e.addr  = m_addr;
    e.valid = m_valid;
    e.busy  = (bytes_q.size() == 1);
    e.err   = m_err;
    return e;
  endfunction

  task automatic model_reset();
    bytes_q.delete();
    m_opc   = 3'd0;
    m_addr  = 13'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic ld, input logic h, input logic [7:0] d);
    logic [15:0] instr;
    if (!r) begin
      model_reset();
    end else begin
      m_err = 1'b0;
      if (!h) begin
        if (ld) begin
          bytes_q.push_back(d);
          if (bytes_q.size() == 2) begin
            instr   = {bytes_q[0], bytes_q[1]};
            m_opc   = instr / 16'd8192;
            m_addr  = instr % 16'd8192;
            m_valid = 1'b1;
            bytes_q.delete();
          end else begin
            m_valid = 1'b0;
          end
        end else if (bytes_q.size() == 1) begin
          bytes_q.delete();
          m_err = 1'b1;
        end
      end
    end
  endtask

  function automatic exp_t dut_now();
    exp_t a;
    a.opc   = opcode;
    a.addr  = ir_addr;
    a.valid = ir_valid;
    a.busy  = fetch_busy;
    a.err   = fetch_err;
    return a;
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got opc=%0d addr=%h valid=%b busy=%b err=%b, expected opc=%0d addr=%h valid=%b busy=%b err=%b",
               name, act.opc, act.addr, act.valid, act.busy, act.err,
               exp.opc, exp.addr, exp.valid, exp.busy, exp.err);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one clock's worth of inputs and queue the expected post-edge outputs.
  task automatic cycle(input logic r, input logic ld, input logic h, input logic [7:0] d);
    @(negedge clk);
    rst     = r;
    load_ir = ld;
    halt    = h;
    data    = d;
    model_step(r, ld, h, d);
    exp_q.push_back(model_now());
  endtask

  // Wait until just after the edge that consumed the last cycle() inputs.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge, compare DUT outputs with the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("scoreboard", dut_now(), e);
      end
    end
  end

  initial begin
    rst = 1'b0; load_ir = 1'b0; halt = 1'b0; data = 8'h00;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    settle();
    check_val("reset_valid", {15'd0, ir_valid}, 16'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Normal fetch E0,12 -> JMP 0x0012
    cycle(1'b1, 1'b1, 1'b0, 8'hE0);
    settle();
    check_val("fetch_busy_hi", {15'd0, fetch_busy}, 16'd1);
    cycle(1'b1, 1'b1, 1'b0, 8'h12);
    settle();
    check_val("jmp_opcode", {13'd0, opcode}, 16'd7);
    check_val("jmp_addr", {3'd0, ir_addr}, 16'h0012);
    check_val("jmp_valid_busy", {14'd0, ir_valid, fetch_busy}, 16'b10);

    // Abort after high byte A0
    cycle(1'b1, 1'b1, 1'b0, 8'hA0);
    cycle(1'b1, 1'b0, 1'b0, 8'h55);
    settle();
    check_val("abort_err", {15'd0, fetch_err}, 16'd1);
    check_val("abort_valid", {15'd0, ir_valid}, 16'd0);
    check_val("abort_keep", {opcode, ir_addr}, {3'd7, 13'h0012});
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    check_val("abort_pulse_end", {15'd0, fetch_err}, 16'd0);

    // Back-to-back four beats
    cycle(1'b1, 1'b1, 1'b0, 8'h40);
    cycle(1'b1, 1'b1, 1'b0, 8'h05);
    settle();
    check_val("b2b_first", {opcode, ir_addr}, {3'd2, 13'h0005});
    cycle(1'b1, 1'b1, 1'b0, 8'hC1);
    settle();
    check_val("b2b_valid_drop", {15'd0, ir_valid}, 16'd0);
    cycle(1'b1, 1'b1, 1'b0, 8'hFF);
    settle();
    check_val("b2b_second", {opcode, ir_addr}, {3'd6, 13'h01FF});
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Halt freeze in HI
    cycle(1'b1, 1'b1, 1'b0, 8'h20);
    cycle(1'b1, 1'b1, 1'b1, 8'h99);
    cycle(1'b1, 1'b0, 1'b1, 8'h77);
    cycle(1'b1, 1'b1, 1'b1, 8'h66);
    settle();
    check_val("halt_frozen", {14'd0, fetch_busy, fetch_err}, 16'b10);
    cycle(1'b1, 1'b1, 1'b0, 8'h34);
    settle();
    check_val("halt_resume", {opcode, ir_addr}, {3'd1, 13'h0034});

    // Width extremes
    cycle(1'b1, 1'b1, 1'b0, 8'hFF);
    cycle(1'b1, 1'b1, 1'b0, 8'hFF);
    settle();
    check_val("all_ones", {opcode, ir_addr}, 16'hFFFF);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    settle();
    check_val("all_zero", {opcode, ir_addr}, 16'h0000);
    check_val("all_zero_valid", {15'd0, ir_valid}, 16'd1);

    // Asynchronous reset mid-HI
    cycle(1'b1, 1'b1, 1'b0, 8'hA5);
    settle();
    rst = 1'b0;
    #1;
    check_val("async_reset", {opcode, ir_addr}, 16'h0000);
    check_val("async_reset_flags", {13'd0, ir_valid, fetch_busy, fetch_err}, 16'd0);
    model_reset();
    cycle(1'b0, 1'b1, 1'b0, 8'hA5);
    cycle(1'b1, 1'b1, 1'b0, 8'h11);
    cycle(1'b1, 1'b1, 1'b0, 8'h22);
    settle();
    check_val("post_reset_fetch", {opcode, ir_addr}, 16'h1122);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 15),
            8'($urandom));
    end
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    settle();
    settle();
    check_val("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instr_register
